// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues word requests,
// and buffers returned instructions with PC/PC+4 for the decode stage.
module fetch_queue #(
    parameter int                    WIDTH_DATA = 32,
    parameter int                    WIDTH_ADDR = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [WIDTH_ADDR-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [WIDTH_ADDR-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [WIDTH_DATA-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [WIDTH_ADDR-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH_DATA-1:0] out_instr,
    output logic [WIDTH_ADDR-1:0] out_pc,
    output logic [WIDTH_ADDR-1:0] out_pcplus4
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW+1:0] DEPTH_W = (CW+2)'(DEPTH);
    localparam logic [WIDTH_ADDR-1:0] FOUR = WIDTH_ADDR'(4);

    typedef struct packed {
        logic [WIDTH_DATA-1:0] instr;
        logic [WIDTH_ADDR-1:0] pc;
    } entry_t;

    entry_t                fifo_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         inflight_q;
    logic [CW-1:0]         drop_q;
    logic [WIDTH_ADDR-1:0] fetch_pc_q;
    logic [WIDTH_ADDR-1:0] rsp_pc_q;

    logic [CW+1:0]         used;
    logic                  credit_ok;
    logic                  req_fire;
    logic                  rsp_drop;
    logic                  rsp_push;
    logic                  pop;
    logic [CW-1:0]         owed;
    logic [CW-1:0]         drop_redir;
    logic [WIDTH_ADDR-1:0] target;
    entry_t                head;
    logic                  unused_pc_lsb;

    // Cancelled-but-unanswered requests still hold a slot until they return.
    assign used = {2'b00, count_q} + {2'b00, inflight_q} + {2'b00, drop_q};
    assign credit_ok = used < DEPTH_W;

    assign imem_req_valid = !rst && !redirect_valid && credit_ok;
    assign imem_req_addr  = rst ? '0 : fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (drop_q != '0);
    assign rsp_push = imem_rsp_valid && (drop_q == '0) && (inflight_q != '0);

    assign target        = {redirect_pc[WIDTH_ADDR-1:2], 2'b00};
    assign unused_pc_lsb = ^redirect_pc[1:0];

    // A response landing in the redirect cycle is already counted as dropped.
    assign owed       = drop_q + inflight_q;
    assign drop_redir = owed - CW'(imem_rsp_valid && (owed != '0));

    assign head        = fifo_q[rd_ptr_q];
    assign out_valid   = !rst && (count_q != '0);
    assign pop         = out_valid && out_ready;
    assign out_instr   = out_valid ? head.instr : '0;
    assign out_pc      = out_valid ? head.pc : '0;
    assign out_pcplus4 = out_valid ? head.pc + FOUR : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else if (redirect_valid) begin
            fetch_pc_q <= target;
            rsp_pc_q   <= target;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= drop_redir;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc_q <= fetch_pc_q + FOUR;
            end
            if (rsp_drop) begin
                drop_q <= drop_q - CW'(1);
            end
            if (rsp_push) begin
                rsp_pc_q <= rsp_pc_q + FOUR;
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            inflight_q <= inflight_q + CW'(req_fire) - CW'(rsp_push);
            count_q    <= count_q + CW'(rsp_push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !redirect_valid && rsp_push) begin
            fifo_q[wr_ptr_q] <= '{instr: imem_rsp_data, pc: rsp_pc_q};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a latency-configurable memory model
// and a scoreboard of expected {pc, instr} entries.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pcplus4;

    fetch_queue #(
        .WIDTH_DATA(32),
        .WIDTH_ADDR(32),
        .DEPTH(DEPTH),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .out_pcplus4(out_pcplus4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    pend_t       pend[$];
    exp_t        sb[$];
    logic [31:0] popped[$];
    logic [31:0] popped_p4[$];

    int          checks;
    int          failures;
    int          cyc;
    int          epoch;
    int          lat;
    int          fires;
    int          s0;
    bit          rsp_en;
    logic [31:0] exp_fetch_pc;
    logic        last_rsp;
    logic        last_pop;
    logic        last_out_valid;
    logic [31:0] last_req_addr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered at posedge+1; drives the memory response, samples at
    // posedge+4, updates the models, and returns at the next posedge+1.
    task automatic cycle();
        pend_t p;
        exp_t  e;
        bit    stale_now;
        int    stale;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        stale_now      = 1'b0;
        if (rsp_en && pend.size() > 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(p.addr);
            stale_now      = (p.epoch != epoch);
        end
        #3;
        last_rsp       = imem_rsp_valid;
        last_pop       = out_valid && out_ready;
        last_out_valid = out_valid;
        last_req_addr  = imem_req_addr;
        if (rst) begin
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_instr", out_instr, 0);
            chk("rst_req_addr", imem_req_addr, 0);
        end else begin
            stale = int'(stale_now);
            foreach (pend[i]) if (pend[i].epoch != epoch) stale++;
            chk("req_valid", imem_req_valid,
                32'(!redirect_valid && (sb.size() + stale < DEPTH)));
            if (imem_req_valid) chk("req_addr", imem_req_addr, exp_fetch_pc);
            if (!out_valid) chk("idle_pc", out_pc, 0);
            if (redirect_valid) begin
                sb.delete();
                epoch++;
                exp_fetch_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("spurious_out", 32'(out_valid), 0);
                    end else begin
                        e = sb.pop_front();
                        chk("out_pc", out_pc, e.pc);
                        chk("out_instr", out_instr, e.data);
                        chk("out_pcplus4", out_pcplus4, e.pc + 32'd4);
                        popped.push_back(out_pc);
                        popped_p4.push_back(out_pcplus4);
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    p.addr  = imem_req_addr;
                    p.epoch = epoch;
                    p.due   = cyc + lat;
                    pend.push_back(p);
                    e.pc   = exp_fetch_pc;
                    e.data = memf(exp_fetch_pc);
                    sb.push_back(e);
                    exp_fetch_pc = exp_fetch_pc + 32'd4;
                    fires++;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        cycle();
        redirect_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        epoch = 0;
        lat = 1;
        fires = 0;
        rsp_en = 1'b0;
        exp_fetch_pc = 32'h0;
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b0;
        #1;
        repeat (3) cycle();
        rst = 1'b0;

        // Request held while memory is not ready.
        out_ready = 1'b1;
        rsp_en = 1'b1;
        repeat (5) cycle();
        imem_req_ready = 1'b1;
        cycle();
        imem_req_ready = 1'b0;
        cycle();
        chk("hold_single_hs", 32'(fires), 1);
        chk("hold_next_addr", last_req_addr, 32'h4);

        // Streaming fetch with 1-cycle memory.
        imem_req_ready = 1'b1;
        repeat (12) cycle();
        chk("seq_pc0", popped[0], 32'h0);
        chk("seq_pc1", popped[1], 32'h4);
        chk("seq_pc2", popped[2], 32'h8);

        // Decode stall fills the queue to DEPTH.
        out_ready = 1'b0;
        s0 = sb.size();
        fires = 0;
        repeat (20) cycle();
        chk("stall_fires", 32'(fires), 32'(DEPTH - s0));
        chk("stall_full", 32'(last_out_valid), 1);
        out_ready = 1'b1;
        repeat (12) cycle();

        // Three in flight, then redirect to 0x100.
        redirect(32'h10);
        imem_req_ready = 1'b0;
        repeat (6) cycle();
        rsp_en = 1'b0;
        imem_req_ready = 1'b1;
        fires = 0;
        repeat (3) cycle();
        imem_req_ready = 1'b0;
        chk("inflight3", 32'(fires), 3);
        redirect(32'h100);
        popped.delete();
        rsp_en = 1'b1;
        imem_req_ready = 1'b1;
        repeat (12) cycle();
        chk("redir_first_pc", popped[0], 32'h100);

        // Redirect colliding with a response and a pop, 2-cycle memory.
        lat = 2;
        repeat (10) cycle();
        redirect(32'h100);
        chk("coll_rsp", 32'(last_rsp), 1);
        chk("coll_pop", 32'(last_pop), 1);
        popped.delete();
        cycle();
        chk("coll_empty", 32'(last_out_valid), 0);
        chk("coll_addr", last_req_addr, 32'h100);
        repeat (12) cycle();
        chk("coll_first_pc", popped[0], 32'h100);

        // Top-of-memory wrap; low target bits ignored.
        lat = 1;
        redirect(32'hFFFF_FFFF);
        popped.delete();
        popped_p4.delete();
        repeat (10) cycle();
        chk("wrap_pc", popped[0], 32'hFFFF_FFFC);
        chk("wrap_p4", popped_p4[0], 32'h0);
        chk("wrap_next", popped[1], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
